// File: rtl/approx_seq_accum_if.sv
// Operand and product handshakes for the sequential approximate multiplier.
interface approx_seq_accum_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/approx_seq_accum.sv
// Shift-and-add multiplier: one partial-product row per cycle, low APPROX_COLS
// columns merged with OR (carry dropped), upper columns added exactly.
module approx_seq_accum #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned APPROX_COLS = 8
) (
  input logic                clk,
  input logic                rst,
  approx_seq_accum_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Column masks; written as shifts so APPROX_COLS of 0 or PW needs no zero-width slice.
  localparam logic [PW-1:0] LO_MASK  = {PW{1'b1}} >> (PW - APPROX_COLS);
  localparam logic [PW-1:0] HI_MASK  = ~LO_MASK;
  localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ra_q, ra_d;
  logic [WIDTH-1:0]  rb_q, rb_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     p_q, p_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [PW-1:0]     pp_c;
  logic [PW-1:0]     acc_next_c;

  // Current partial-product row and its merge into the accumulator.
  always_comb begin
    pp_c = '0;
    if (rb_q[cnt_q]) begin
      pp_c = PW'(ra_q) << cnt_q;
    end
    acc_next_c = ((acc_q | pp_c) & LO_MASK)
               | (((acc_q & HI_MASK) + (pp_c & HI_MASK)) & HI_MASK);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ROW) begin
          p_d     = acc_next_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered from the next state, so they carry no input path.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;

endmodule

// File: tb/tb_approx_seq_accum.sv
// Bench for approx_seq_accum: an approximate (8 OR columns) and an exact instance run in lockstep.
module tb_approx_seq_accum;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_seq_accum_if #(.WIDTH(W)) bus8();
  approx_seq_accum_if #(.WIDTH(W)) bus0();

  approx_seq_accum #(.WIDTH(W), .APPROX_COLS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  approx_seq_accum #(.WIDTH(W), .APPROX_COLS(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: rows are summed above column k and OR-ed below it.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input int k);
    longint unsigned lo, hi, row, mask;
    lo = 0;
    hi = 0;
    for (int i = 0; i < int'(W); i++) begin
      if (b[i]) begin
        row = longint'(a) << i;
        lo  = lo | row;
        hi  = hi + (row >> k);
      end
    end
    mask = (k == 0) ? 64'd0 : ((64'd1 << k) - 64'd1);
    return 32'((lo & mask) | (hi << k));
  endfunction

  function automatic logic [31:0] exact(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic ordy);
    bus8.in_valid = v;  bus8.a = a;  bus8.b = b;  bus8.out_ready = ordy;
    bus0.in_valid = v;  bus0.a = a;  bus0.b = b;  bus0.out_ready = ordy;
  endtask

  function automatic logic [3:0] flags();
    return {bus8.out_valid, bus8.in_ready, bus0.out_valid, bus0.in_ready};
  endfunction

  // One transaction; 'hold' cycles of backpressure with junk operands offered meanwhile.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [31:0] p8, output logic [31:0] p0, output int lat);
    int guard;
    guard = 0;
    while (!bus8.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_accept", 64'(flags()), 64'(4'b0101));
    drive(1'b1, a, b, 1'b0);
    @(negedge clk);
    chk("busy_after_accept", 64'(flags()), 64'(4'b0000));
    drive(1'b0, 16'($urandom), 16'($urandom), 1'b0);
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_flags", 64'(flags()), 64'(4'b1010));
    p8 = bus8.p;
    p0 = bus0.p;
    for (int h = 0; h < hold; h++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      @(negedge clk);
      chk("bp_p_stable", 64'({bus8.p, bus0.p}), 64'({p8, p0}));
      chk("bp_flags", 64'(flags()), 64'(4'b1010));
    end
    // in_valid stays high across the release edge when held; it must not be taken there.
    drive(hold > 0, 16'($urandom), 16'($urandom), 1'b1);
    @(negedge clk);
    chk("after_release", 64'(flags()), 64'(4'b0101));
    drive(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  logic [31:0] p8, p0;
  int          lat;
  logic [15:0] ra, rb;
  logic [15:0] ba[4], bb[4];
  int          sent, got, last_cyc;
  logic        seen;

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_flags", 64'(flags()), 64'(4'b0101));
    chk("reset_p", 64'({bus8.p, bus0.p}), 64'd0);

    run_op(16'h00FF, 16'h00FF, 0, p8, p0, lat);
    chk("ff_ff_approx", 64'(p8), 64'(32'h0000F7FF));
    chk("ff_ff_exact", 64'(p0), 64'(32'h0000FE01));
    chk("latency", 64'(lat), 64'd16);

    run_op(16'h0003, 16'h0003, 0, p8, p0, lat);
    chk("3x3_approx", 64'(p8), 64'(32'h00000007));
    chk("3x3_exact", 64'(p0), 64'(32'h00000009));

    run_op(16'hFFFF, 16'h0001, 0, p8, p0, lat);
    chk("ffff_x1_approx", 64'(p8), 64'(32'h0000FFFF));
    chk("ffff_x1_exact", 64'(p0), 64'(32'h0000FFFF));

    run_op(16'h1234, 16'h0000, 0, p8, p0, lat);
    chk("x0_approx", 64'(p8), 64'd0);
    chk("x0_exact", 64'(p0), 64'd0);

    run_op(16'hFFFF, 16'hFFFF, 0, p8, p0, lat);
    chk("max_exact", 64'(p0), 64'(32'hFFFE0001));
    chk("max_approx", 64'(p8), 64'(model(16'hFFFF, 16'hFFFF, 8)));

    // Backpressure for 5 cycles with fresh operands offered during the stall.
    ra = 16'($urandom);
    rb = 16'($urandom);
    run_op(ra, rb, 5, p8, p0, lat);
    chk("bp_approx", 64'(p8), 64'(model(ra, rb, 8)));
    chk("bp_exact", 64'(p0), 64'(exact(ra, rb)));
    @(negedge clk);
    chk("bp_no_accept", 64'(flags()), 64'(4'b0101));

    // Reset on the fifth BUSY edge discards the operation.
    drive(1'b1, 16'hABCD, 16'h1234, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_flags", 64'(flags()), 64'(4'b0101));
    chk("midrst_p", 64'({bus8.p, bus0.p}), 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus8.out_valid | bus0.out_valid;
    end
    chk("midrst_no_output", 64'(seen), 64'd0);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    run_op(16'd2, 16'd3, 0, p8, p0, lat);
    chk("post_rst_approx", 64'(p8), 64'd6);
    chk("post_rst_exact", 64'(p0), 64'd6);

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      ba[i] = 16'($urandom);
      bb[i] = 16'($urandom);
    end
    sent = 0;
    got = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (bus8.out_valid) begin
        if (got < 4) begin
          chk("b2b_approx", 64'(bus8.p), 64'(model(ba[got], bb[got], 8)));
          chk("b2b_exact", 64'(bus0.p), 64'(exact(ba[got], bb[got])));
          if (got > 0) chk("b2b_spacing", 64'(cyc - last_cyc), 64'd18);
        end
        last_cyc = cyc;
        got++;
      end
      if (bus8.in_ready) begin
        if (sent < 4) drive(1'b1, ba[sent], bb[sent], 1'b1);
        else          drive(1'b0, 16'h0, 16'h0, 1'b1);
        sent++;
      end
      @(negedge clk);
    end
    chk("b2b_count", 64'(got), 64'd4);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);

    // Random pairs: exact instance against true product, approximate against the model.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 10 == 0) ra = 16'hFFFF;
      if (n % 13 == 0) rb = 16'hFFFF;
      run_op(ra, rb, 0, p8, p0, lat);
      chk("rnd_exact", 64'(p0), 64'(exact(ra, rb)));
      chk("rnd_approx", 64'(p8), 64'(model(ra, rb, 8)));
      chk("rnd_latency", 64'(lat), 64'd16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
